// File: rtl/pcie_phy_pkg.sv
// Shared PHY types: link data rate encoding.
package pcie_phy_pkg;

    typedef enum logic [2:0] {
        GEN1 = 3'd0,
        GEN2 = 3'd1,
        GEN3 = 3'd2,
        GEN4 = 3'd3,
        GEN5 = 3'd4
    } rate_speed_e;

endpackage

// File: rtl/block_align_ctrl.sv
// Per-lane 128b/130b block alignment (UNALIGNED -> ALIGNED on EIEOS, LOCKED on SDS).
// Define BLOCK_ALIGN_ERR_CNT_EN to add per-lane saturating sync-header error counters.
module block_align_ctrl
    import pcie_phy_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned MAX_NUM_LANES = 4,
    parameter int unsigned BAD_SH_LIMIT  = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                phy_link_up_i,
    input  rate_speed_e                         curr_data_rate_i,
    input  logic [5:0]                          num_active_lanes_i,
    input  logic [MAX_NUM_LANES*DATA_WIDTH-1:0] data_i,
    input  logic [MAX_NUM_LANES-1:0]            data_valid_i,
    input  logic [2*MAX_NUM_LANES-1:0]          sync_header_i,
    output logic [MAX_NUM_LANES-1:0]            block_start_o,
    output logic [MAX_NUM_LANES-1:0]            block_aligned_o,
    output logic [MAX_NUM_LANES-1:0]            block_locked_o,
    output logic                                all_locked_o,
    output logic [MAX_NUM_LANES-1:0]            sh_err_o,
    output logic [8*MAX_NUM_LANES-1:0]          err_cnt_o
);

    localparam logic [DATA_WIDTH-1:0] EIEOS_BEAT  = 32'hFF00FF00;
    localparam logic [7:0]            SDS_BYTE    = 8'hE1;
    localparam int unsigned           BAD_W       = $clog2(BAD_SH_LIMIT + 1);
    localparam logic [BAD_W-1:0]      BAD_LIMIT_V = BAD_W'(BAD_SH_LIMIT);
    localparam logic [5:0]            NAL_MAX     = 6'(MAX_NUM_LANES);

    typedef enum logic [1:0] {
        StUnaligned = 2'd0,
        StAligned   = 2'd1,
        StLocked    = 2'd2
    } lane_state_e;

    logic [5:0]               r_nal_prev;
    logic                     r_all_locked;
    logic                     w_run;
    logic                     w_nal_ok;
    logic                     w_all_locked_nxt;
    logic [MAX_NUM_LANES-1:0] w_locked_nxt;
    logic [MAX_NUM_LANES-1:0] w_lane_mask;

    // Any change of lane count, link loss or a non-128b/130b rate realigns every lane.
    assign w_run = phy_link_up_i && (curr_data_rate_i >= GEN3) &&
                   (num_active_lanes_i == r_nal_prev);

    assign w_nal_ok         = (num_active_lanes_i != 6'd0) && (num_active_lanes_i <= NAL_MAX);
    assign w_all_locked_nxt = w_nal_ok && (&(w_locked_nxt | ~w_lane_mask));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_nal_prev   <= 6'd0;
            r_all_locked <= 1'b0;
        end else begin
            r_nal_prev   <= num_active_lanes_i;
            r_all_locked <= w_all_locked_nxt;
        end
    end

    assign all_locked_o = r_all_locked;

    for (genvar g = 0; g < MAX_NUM_LANES; g++) begin : g_lane
        localparam logic [5:0] LANE_IDX = 6'(g);

        lane_state_e           r_state;
        lane_state_e           w_state_nxt;
        logic [1:0]            r_beat;
        logic [1:0]            w_beat_nxt;
        logic [1:0]            r_eie_cnt;
        logic [1:0]            w_eie_nxt;
        logic [BAD_W-1:0]      r_bad;
        logic [BAD_W-1:0]      w_bad_nxt;
        logic [BAD_W-1:0]      w_bad_inc;
        logic                  r_start;
        logic                  w_start_nxt;
        logic                  r_sh_err;
        logic                  w_sh_err_nxt;
        logic [DATA_WIDTH-1:0] w_beat_data;
        logic [1:0]            w_sh;
        logic                  w_active;
        logic                  w_valid;
        logic                  w_eieos;
        logic                  w_eieos_done;
        logic                  w_sh_bad;
        logic                  w_sds;
        logic                  w_beat0;

        assign w_beat_data  = data_i[g*DATA_WIDTH +: DATA_WIDTH];
        assign w_sh         = sync_header_i[2*g +: 2];
        assign w_valid      = data_valid_i[g];
        assign w_lane_mask[g] = LANE_IDX < num_active_lanes_i;
        assign w_active     = w_run && w_lane_mask[g];
        assign w_eieos      = w_beat_data == EIEOS_BEAT;
        assign w_eieos_done = w_eieos && (r_eie_cnt == 2'd3);
        assign w_sh_bad     = (w_sh == 2'b00) || (w_sh == 2'b11);
        assign w_sds        = (w_sh == 2'b10) && (w_beat_data[7:0] == SDS_BYTE);
        assign w_beat0      = r_beat == 2'd0;
        assign w_bad_inc    = (r_bad >= BAD_LIMIT_V) ? r_bad : r_bad + 1'b1;

        always_comb begin
            w_state_nxt  = r_state;
            w_beat_nxt   = r_beat;
            w_eie_nxt    = r_eie_cnt;
            w_bad_nxt    = r_bad;
            w_start_nxt  = 1'b0;
            w_sh_err_nxt = 1'b0;
            if (!w_active) begin
                w_state_nxt = StUnaligned;
                w_beat_nxt  = 2'd0;
                w_eie_nxt   = 2'd0;
                w_bad_nxt   = '0;
            end else if (w_valid) begin
                w_beat_nxt = r_beat + 2'd1;
                unique case (r_state)
                    StUnaligned: begin
                        w_beat_nxt = 2'd0;
                        if (w_eieos_done) begin
                            w_state_nxt = StAligned;
                            w_eie_nxt   = 2'd0;
                        end else if (w_eieos) begin
                            w_eie_nxt = r_eie_cnt + 2'd1;
                        end else begin
                            w_eie_nxt = 2'd0;
                        end
                    end
                    StAligned: begin
                        w_start_nxt = w_beat0;
                        if (w_beat0 && w_sh_bad) begin
                            w_state_nxt  = StUnaligned;
                            w_sh_err_nxt = 1'b1;
                            w_beat_nxt   = 2'd0;
                            w_eie_nxt    = 2'd0;
                        end else if (w_beat0 && w_sds) begin
                            w_state_nxt = StLocked;
                            w_bad_nxt   = '0;
                            w_eie_nxt   = 2'd0;
                        end
                    end
                    StLocked: begin
                        w_start_nxt = w_beat0;
                        w_eie_nxt   = w_eieos ? r_eie_cnt + 2'd1 : 2'd0;
                        if (w_beat0 && w_sh_bad) begin
                            w_sh_err_nxt = 1'b1;
                            w_bad_nxt    = w_bad_inc;
                        end
                        // A completed EIEOS takes priority over hitting the bad-header limit.
                        if (w_eieos_done) begin
                            w_state_nxt = StAligned;
                            w_beat_nxt  = 2'd0;
                            w_eie_nxt   = 2'd0;
                        end else if (w_beat0 && w_sh_bad && (w_bad_inc >= BAD_LIMIT_V)) begin
                            w_state_nxt = StUnaligned;
                            w_beat_nxt  = 2'd0;
                            w_eie_nxt   = 2'd0;
                            w_bad_nxt   = '0;
                        end
                    end
                    default: begin
                        w_state_nxt = StUnaligned;
                        w_beat_nxt  = 2'd0;
                        w_eie_nxt   = 2'd0;
                        w_bad_nxt   = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_state   <= StUnaligned;
                r_beat    <= 2'd0;
                r_eie_cnt <= 2'd0;
                r_bad     <= '0;
                r_start   <= 1'b0;
                r_sh_err  <= 1'b0;
            end else begin
                r_state   <= w_state_nxt;
                r_beat    <= w_beat_nxt;
                r_eie_cnt <= w_eie_nxt;
                r_bad     <= w_bad_nxt;
                r_start   <= w_start_nxt;
                r_sh_err  <= w_sh_err_nxt;
            end
        end

        assign w_locked_nxt[g]    = w_state_nxt == StLocked;
        assign block_start_o[g]   = r_start;
        assign block_aligned_o[g] = r_state != StUnaligned;
        assign block_locked_o[g]  = r_state == StLocked;
        assign sh_err_o[g]        = r_sh_err;

`ifdef BLOCK_ALIGN_ERR_CNT_EN
        logic [7:0] r_err_cnt;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_err_cnt <= 8'h00;
            end else if (w_sh_err_nxt && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end

        assign err_cnt_o[8*g +: 8] = r_err_cnt;
`else
        assign err_cnt_o[8*g +: 8] = 8'h00;
`endif
    end

endmodule

// File: tb/tb_block_align_ctrl.sv
// Self-checking bench for block_align_ctrl: directed scenarios plus randomized traffic vs. a model.
module tb_block_align_ctrl;
    import pcie_phy_pkg::*;

    localparam int          NL     = 4;
    localparam int          LIMIT  = 4;
    localparam logic [31:0] EIEOS  = 32'hFF00FF00;
    localparam int          MU     = 0;
    localparam int          MA     = 1;
    localparam int          ML     = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         link = 1'b1;
    rate_speed_e  rate = GEN3;
    logic [5:0]   nal = 6'd4;
    logic [127:0] data = '0;
    logic [3:0]   valid = '0;
    logic [7:0]   sh = '0;
    logic [3:0]   block_start_o, block_aligned_o, block_locked_o, sh_err_o;
    logic         all_locked_o;
    logic [31:0]  err_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: lane mode, consecutive-EIEOS run, valid beats since alignment point, bad headers.
    int         m_state[NL];
    int         m_run[NL];
    int         m_since[NL];
    int         m_bad[NL];
    int         m_err[NL];
    logic [5:0] m_nal_prev;
    logic [3:0] e_start, e_err;
    logic       e_all;

    block_align_ctrl dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .phy_link_up_i      (link),
        .curr_data_rate_i   (rate),
        .num_active_lanes_i (nal),
        .data_i             (data),
        .data_valid_i       (valid),
        .sync_header_i      (sh),
        .block_start_o      (block_start_o),
        .block_aligned_o    (block_aligned_o),
        .block_locked_o     (block_locked_o),
        .all_locked_o       (all_locked_o),
        .sh_err_o           (sh_err_o),
        .err_cnt_o          (err_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic lane_clear(input int l);
        m_state[l] = MU;
        m_run[l]   = 0;
        m_since[l] = 0;
        m_bad[l]   = 0;
    endtask

    task automatic model_reset();
        for (int l = 0; l < NL; l++) begin
            lane_clear(l);
            m_err[l] = 0;
        end
        m_nal_prev = 6'd0;
        e_start    = '0;
        e_err      = '0;
        e_all      = 1'b0;
    endtask

    task automatic model_step();
        bit run;
        run = link && (rate >= GEN3) && (nal == m_nal_prev);
        m_nal_prev = nal;
        e_start = '0;
        e_err   = '0;
        for (int l = 0; l < NL; l++) begin
            logic [31:0] d;
            logic [1:0]  s;
            bit          eie, badh, idx0;
            d = data[l*32 +: 32];
            s = sh[l*2 +: 2];
            if (!run || l >= int'(nal)) begin
                lane_clear(l);
            end else if (valid[l]) begin
                eie  = (d == EIEOS);
                badh = (s == 2'b00) || (s == 2'b11);
                idx0 = (m_since[l] % 4) == 0;
                m_run[l] = eie ? m_run[l] + 1 : 0;
                case (m_state[l])
                    MU: begin
                        m_since[l] = 0;
                        if (m_run[l] >= 4) begin
                            m_state[l] = MA;
                            m_run[l]   = 0;
                        end
                    end
                    MA: begin
                        e_start[l] = idx0;
                        m_since[l]++;
                        if (idx0 && badh) begin
                            e_err[l] = 1'b1;
                            lane_clear(l);
                        end else if (idx0 && s == 2'b10 && d[7:0] == 8'hE1) begin
                            m_state[l] = ML;
                            m_bad[l]   = 0;
                            m_run[l]   = 0;
                        end
                    end
                    default: begin
                        e_start[l] = idx0;
                        m_since[l]++;
                        if (idx0 && badh) begin
                            e_err[l] = 1'b1;
                            if (m_bad[l] < LIMIT) m_bad[l]++;
                        end
                        if (m_run[l] >= 4) begin
                            m_state[l] = MA;
                            m_run[l]   = 0;
                            m_since[l] = 0;
                        end else if (m_bad[l] >= LIMIT) begin
                            lane_clear(l);
                        end
                    end
                endcase
                if (e_err[l] && m_err[l] < 255) m_err[l]++;
            end
        end
        e_all = (nal >= 6'd1) && (nal <= 6'd4);
        for (int l = 0; l < NL; l++) begin
            if (l < int'(nal) && m_state[l] != ML) e_all = 1'b0;
        end
    endtask

    task automatic compare_all(input string tag);
        logic [3:0]  ea, el;
        logic [31:0] ec;
        for (int l = 0; l < NL; l++) begin
            ea[l] = m_state[l] != MU;
            el[l] = m_state[l] == ML;
`ifdef BLOCK_ALIGN_ERR_CNT_EN
            ec[l*8 +: 8] = 8'(m_err[l]);
`else
            ec[l*8 +: 8] = 8'h00;
`endif
        end
        check({tag, ".aligned"}, 64'(block_aligned_o), 64'(ea));
        check({tag, ".locked"}, 64'(block_locked_o), 64'(el));
        check({tag, ".start"}, 64'(block_start_o), 64'(e_start));
        check({tag, ".sh_err"}, 64'(sh_err_o), 64'(e_err));
        check({tag, ".all_locked"}, 64'(all_locked_o), 64'(e_all));
        check({tag, ".err_cnt"}, 64'(err_cnt_o), 64'(ec));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_all("model");
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        model_reset();
        compare_all("in_reset");
        @(posedge clk);
        #1;
        compare_all("in_reset_edge");
        rst = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d, input logic [1:0] s, input logic [3:0] v);
        data  = {4{d}};
        sh    = {4{s}};
        valid = v;
        cycle();
    endtask

    task automatic lock_all();
        link = 1'b0;
        beat(32'h0, 2'b01, 4'h0);
        link = 1'b1;
        beat(32'h0, 2'b01, 4'h0);
        repeat (4) beat(EIEOS, 2'b10, 4'hF);
        beat(32'h000000E1, 2'b10, 4'hF);
    endtask

    int pulses;

    initial begin
        model_reset();
        #1;
        do_reset();
        check("reset_aligned", 64'(block_aligned_o), 64'h0);
        check("reset_all_locked", 64'(all_locked_o), 64'h0);
        beat(32'h0, 2'b01, 4'h0);

        // Lane 0 aligns on the fourth EIEOS beat; the next beat starts a block.
        repeat (3) beat(EIEOS, 2'b10, 4'h1);
        check("eieos3_not_aligned", 64'(block_aligned_o), 64'h0);
        beat(EIEOS, 2'b10, 4'h1);
        check("eieos4_aligned", 64'(block_aligned_o), 64'h1);
        beat(32'h0, 2'b01, 4'h1);
        check("first_block_start", 64'(block_start_o), 64'h1);

        lock_all();
        check("sds_locked", 64'(block_locked_o), 64'hF);
        check("sds_all_locked", 64'(all_locked_o), 64'h1);

        // Four bad beat-0 headers on lane 0 while it stays locked until the limit.
        repeat (3) beat(32'h0, 2'b01, 4'h1);
        pulses = 0;
        for (int b = 0; b < 4; b++) begin
            beat(32'h0, 2'b11, 4'h1);
            pulses += int'(sh_err_o[0]);
            repeat (3) begin
                beat(32'h0, 2'b01, 4'h1);
                pulses += int'(sh_err_o[0]);
            end
        end
        check("bad_sh_pulses", 64'(pulses), 64'd4);
        check("bad_sh_unaligned", 64'(block_aligned_o), 64'hE);
        check("bad_sh_all_locked", 64'(all_locked_o), 64'h0);
`ifdef BLOCK_ALIGN_ERR_CNT_EN
        check("err_cnt_lane0", 64'(err_cnt_o[7:0]), 64'd4);
`else
        check("err_cnt_lane0", 64'(err_cnt_o[7:0]), 64'd0);
`endif

        // One-cycle link drop clears every lane.
        lock_all();
        link = 1'b0;
        beat(32'h0, 2'b01, 4'hF);
        link = 1'b1;
        check("linkdrop_aligned", 64'(block_aligned_o), 64'h0);
        check("linkdrop_all_locked", 64'(all_locked_o), 64'h0);
        check("linkdrop_start", 64'(block_start_o), 64'h0);

        // A broken EIEOS run restarts the match.
        beat(32'h0, 2'b01, 4'h0);
        repeat (3) beat(EIEOS, 2'b10, 4'h1);
        beat(32'h12345678, 2'b10, 4'h1);
        repeat (3) beat(EIEOS, 2'b10, 4'h1);
        check("broken_run_not_aligned", 64'(block_aligned_o), 64'h0);
        beat(EIEOS, 2'b10, 4'h1);
        check("broken_run_aligned", 64'(block_aligned_o), 64'h1);

        // EIEOS completion and the bad-header limit on the same beat: EIEOS wins.
        lock_all();
        repeat (3) beat(32'h0, 2'b01, 4'h1);
        repeat (2) begin
            beat(32'h0, 2'b11, 4'h1);
            repeat (3) beat(32'h0, 2'b01, 4'h1);
        end
        beat(32'h0, 2'b11, 4'h1);
        repeat (3) beat(EIEOS, 2'b01, 4'h1);
        beat(EIEOS, 2'b11, 4'h1);
        check("tie_sh_err", 64'(sh_err_o), 64'h1);
        check("tie_aligned", 64'(block_aligned_o), 64'hF);
        check("tie_locked", 64'(block_locked_o), 64'hE);

        // Below GEN3 the FSMs never leave UNALIGNED.
        link = 1'b0;
        beat(32'h0, 2'b01, 4'h0);
        link = 1'b1;
        rate = GEN1;
        repeat (6) beat(EIEOS, 2'b10, 4'hF);
        check("gen1_not_aligned", 64'(block_aligned_o), 64'h0);
        rate = GEN3;

        for (int c = 0; c < 6000; c++) begin
            logic [31:0] tmp;
            int          r;
            if ($urandom_range(0, 999) == 0) do_reset();
            link = ($urandom_range(0, 199) != 0);
            r = $urandom_range(0, 99);
            rate = (r < 3) ? rate_speed_e'($urandom_range(0, 1)) :
                             rate_speed_e'($urandom_range(2, 4));
            if ($urandom_range(0, 299) == 0) nal = 6'($urandom_range(0, 6));
            else if ($urandom_range(0, 299) == 0) nal = 6'd4;
            for (int l = 0; l < NL; l++) begin
                valid[l] = ($urandom_range(0, 9) < 8);
                tmp = $urandom();
                r   = $urandom_range(0, 99);
                if (r < 55)      data[l*32 +: 32] = EIEOS;
                else if (r < 75) data[l*32 +: 32] = {tmp[31:8], 8'hE1};
                else             data[l*32 +: 32] = tmp;
                r = $urandom_range(0, 99);
                if (r < 45)      sh[l*2 +: 2] = 2'b10;
                else if (r < 85) sh[l*2 +: 2] = 2'b01;
                else if (r < 92) sh[l*2 +: 2] = 2'b00;
                else             sh[l*2 +: 2] = 2'b11;
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
